// File: rtl/rfphoenix_mem_resp_sched.sv
// Memory-response scheduler: round-robin arbitration onto the response FIFO write port,
// and a drain FSM from the FIFO head to a valid/ready writeback port with rollback discard.
package rfphoenix_mem_pkg;
    localparam int unsigned NTHREADS = 4;
    localparam int unsigned TW       = $clog2(NTHREADS);

    typedef struct packed {
        logic          v;
        logic [TW-1:0] thread;
        logic [7:0]    tag;
        logic [31:0]   res;
    } MemoryArg_t;
endpackage

module rfphoenix_mem_resp_sched
    import rfphoenix_mem_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DEP  = 16,
    parameter int unsigned CW   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  MemoryArg_t [NREQ-1:0]   req_data,
    output logic [NREQ-1:0]         ack,
    output logic                    fifo_wr,
    output MemoryArg_t              fifo_di,
    input  logic [$clog2(DEP)-1:0]  fifo_cnt,
    output logic                    fifo_rd,
    input  MemoryArg_t              fifo_dout,
    input  logic                    fifo_empty,
    input  logic [NTHREADS-1:0]     rollback,
    output logic                    wb_valid,
    output MemoryArg_t              wb_data,
    input  logic                    wb_ready,
    output logic [CW-1:0]           drop_cnt
);
    localparam int unsigned RRW = $clog2(NREQ);
    localparam int unsigned DW  = CW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } rd_state_e;

    logic [NREQ-1:0] ack_q, ack_d;
    logic            fifo_wr_q, fifo_wr_d;
    MemoryArg_t      fifo_di_q, fifo_di_d;
    logic [RRW-1:0]  rr_q, rr_d;
    logic            fifo_rd_q, fifo_rd_d;
    logic            wb_valid_q, wb_valid_d;
    MemoryArg_t      wb_data_q, wb_data_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    rd_state_e       state_q, state_d;

    logic            room;
    logic [NREQ-1:0] eligible;
    logic            grant_found;
    logic [RRW-1:0]  grant_idx;
    logic            wr_drop;
    logic            rd_drop;
    logic [DW-1:0]   drop_sum;

    function automatic logic [RRW-1:0] wrap_idx(input logic [RRW-1:0] base, input int unsigned off);
        return RRW'((32'(base) + off) % NREQ);
    endfunction

    // Write arbiter; the in-flight write counts against room so the FIFO is never overfilled
    always_comb begin
        ack_d       = '0;
        fifo_wr_d   = 1'b0;
        fifo_di_d   = fifo_di_q;
        rr_d        = rr_q;
        wr_drop     = 1'b0;
        grant_found = 1'b0;
        grant_idx   = '0;
        room        = (32'(fifo_cnt) + 32'(fifo_wr_q)) < (DEP - 1);
        eligible    = req & ~ack_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!grant_found && eligible[wrap_idx(rr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(rr_q, k);
            end
        end
        if (room && grant_found) begin
            ack_d[grant_idx] = 1'b1;
            rr_d             = wrap_idx(grant_idx, 1);
            if (rollback[req_data[grant_idx].thread]) begin
                wr_drop = 1'b1;
            end else begin
                fifo_wr_d = 1'b1;
                fifo_di_d = req_data[grant_idx];
            end
        end
    end

    // Read FSM: fifo_rd is high during LOAD, wb_valid high during HOLD
    always_comb begin
        state_d    = state_q;
        fifo_rd_d  = 1'b0;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        rd_drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = LOAD;
                    fifo_rd_d = 1'b1;
                end
            end
            LOAD: begin
                wb_data_d = fifo_dout;
                if (!fifo_dout.v || rollback[fifo_dout.thread]) begin
                    rd_drop = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d    = HOLD;
                    wb_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (wb_ready) begin
                    state_d = IDLE;
                end else if (rollback[wb_data_q.thread]) begin
                    rd_drop = 1'b1;
                    state_d = IDLE;
                end else begin
                    wb_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating drop counter; both sides may drop in the same cycle
    always_comb begin
        drop_sum   = DW'(drop_cnt_q) + DW'(wr_drop) + DW'(rd_drop);
        drop_cnt_d = drop_sum[CW] ? {CW{1'b1}} : drop_sum[CW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q      <= '0;
            fifo_wr_q  <= 1'b0;
            fifo_di_q  <= '0;
            rr_q       <= '0;
            fifo_rd_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            drop_cnt_q <= '0;
            state_q    <= IDLE;
        end else begin
            ack_q      <= ack_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_di_q  <= fifo_di_d;
            rr_q       <= rr_d;
            fifo_rd_q  <= fifo_rd_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= state_d;
        end
    end

    assign ack      = ack_q;
    assign fifo_wr  = fifo_wr_q;
    assign fifo_di  = fifo_di_q;
    assign fifo_rd  = fifo_rd_q;
    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign drop_cnt = drop_cnt_q;

endmodule
